// File: rtl/rca_digit_serial.sv
// rca_digit_serial
//   Digit-serial adder/subtractor. A WIDTH-bit add (or a-b as a+~b+1) is
//   computed DIGIT bits per clock, LSB digit first, through one DIGIT-bit
//   ripple-carry slice. A registered carry links the digits.
//   WIDTH must be a multiple of DIGIT; NDIG = WIDTH/DIGIT cycles per operation.
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   start        request, accepted on a rising edge when start && ready
//   ready        high in IDLE/DONE (a start would be accepted)
//   busy         high while digits are being processed
//   a, b, cin    operands, sampled only on the accept edge (cin ignored for sub)
//   sub          0: a+b+cin, 1: a-b
//   sum          registered result, updated only when an operation completes
//   cout         carry out of the MSB (for sub, 1 = no borrow)
//   ovf          two's-complement overflow
//   done         one-cycle pulse while sum/cout/ovf hold a fresh result
module rca_digit_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    output logic             busy,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             done
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [KW-1:0]    k;

    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] res_next;
    logic             last;
    logic             msb_cin;

    // Operands shift right one digit per cycle so the slice always works on
    // the low digit; the result fills in from the top, so after NDIG cycles
    // digit 0 has reached the bottom.
    always_comb begin
        slice    = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry};
        res_next = WIDTH'({slice[DIGIT-1:0], res} >> DIGIT);
        last     = (k == KW'(NDIG - 1));
        // Carry into the top bit of the slice recovered from its sum bit.
        msb_cin  = slice[DIGIT-1] ^ op_a[DIGIT-1] ^ op_b[DIGIT-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            k     <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
            ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        k     <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                        ready <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> DIGIT;
                    op_b  <= op_b >> DIGIT;
                    res   <= res_next;
                    carry <= slice[DIGIT];
                    if (last) begin
                        sum   <= res_next;
                        cout  <= slice[DIGIT];
                        ovf   <= msb_cin ^ slice[DIGIT];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rca_digit_serial.sv
// Bench for rca_digit_serial: a WIDTH=16/DIGIT=4 instance checked every cycle
// against an arithmetic model, plus DIGIT=1 and DIGIT=16 instances for the
// back-to-back interval cases. Directed vectors carry literal expectations.
module tb_rca_digit_serial;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0, sub = 1'b0;
    logic        ready, busy, cout, ovf, done;
    logic [15:0] sum;

    // alternate instances (DIGIT=1 and DIGIT=16), one selected at a time
    logic        st_alt = 1'b0, sel16 = 1'b0;
    logic        ready1, busy1, cout1, ovf1, done1;
    logic        ready16, busy16, cout16, ovf16, done16;
    logic [15:0] sum1, sum16;
    logic        alt_done, alt_ready, alt_cout;
    logic [15:0] alt_sum;

    int n_tests = 0, n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rca_digit_serial #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .busy(busy),
        .a(a), .b(b), .cin(cin), .sub(sub), .sum(sum), .cout(cout), .ovf(ovf), .done(done));
    rca_digit_serial #(.WIDTH(16), .DIGIT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st_alt & ~sel16), .ready(ready1), .busy(busy1),
        .a(a), .b(b), .cin(cin), .sub(sub), .sum(sum1), .cout(cout1), .ovf(ovf1), .done(done1));
    rca_digit_serial #(.WIDTH(16), .DIGIT(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(st_alt & sel16), .ready(ready16), .busy(busy16),
        .a(a), .b(b), .cin(cin), .sub(sub), .sum(sum16), .cout(cout16), .ovf(ovf16), .done(done16));

    assign alt_done  = sel16 ? done16  : done1;
    assign alt_ready = sel16 ? ready16 : ready1;
    assign alt_sum   = sel16 ? sum16   : sum1;
    assign alt_cout  = sel16 ? cout16  : cout1;

    // reference arithmetic: returns {cout, ovf, sum}
    function automatic logic [17:0] ref_op(input logic [15:0] x, y, input logic ci, s);
        logic [16:0] full;
        logic [15:0] r;
        logic        v;
        if (s) full = {1'b0, x} - {1'b0, y} + 17'h10000;
        else   full = {1'b0, x} + {1'b0, y} + {16'd0, ci};
        r = full[15:0];
        if (s) v = (x[15] != y[15]) && (r[15] != x[15]);
        else   v = (x[15] == y[15]) && (r[15] != x[15]);
        return {full[16], v, r};
    endfunction

    // model for the DIGIT=4 instance: an accepted request completes 4 edges later
    int          m_cnt = 0;
    logic [17:0] m_pend = '0;
    logic [15:0] m_sum = '0;
    logic        m_cout = 0, m_ovf = 0, m_done = 0, m_ready = 1, m_busy = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt <= 0; m_sum <= '0; m_cout <= 0; m_ovf <= 0;
            m_done <= 0; m_ready <= 1; m_busy <= 0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                {m_cout, m_ovf, m_sum} <= m_pend;
                m_done <= 1; m_ready <= 1; m_busy <= 0;
            end
        end else begin
            m_done <= 0;
            if (start) begin
                m_pend <= ref_op(a, b, cin, sub);
                m_cnt <= 4; m_busy <= 1; m_ready <= 0;
            end else begin
                m_ready <= 1; m_busy <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) if (chk_en)
        check("model", {ready, busy, done, cout, ovf, sum},
              {11'd0, m_ready, m_busy, m_done, m_cout, m_ovf, m_sum});

    task automatic go(input logic [15:0] ia, ib, input logic ic, is);
        @(negedge clk);
        a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // wait (bounded) until the main done is seen at a negedge; n = negedges waited
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin @(negedge clk); n++; end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_alt(output int n);
        n = 0;
        while (!alt_done && n < 40) begin @(negedge clk); n++; end
        if (!alt_done) check("alt_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_res(input string name, input logic [15:0] es, input logic ec, ev);
        check(name, {cout, ovf, sum}, {14'd0, ec, ev, es});
    endtask

    // back-to-back on the selected alternate instance, ndig digits per op
    task automatic b2b_alt(input string name, input int ndig);
        int n;
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 0; sub = 0; st_alt = 1;
        @(negedge clk); st_alt = 0;
        wait_alt(n);
        check({name, "_lat"}, n, ndig);
        check({name, "_r1"}, {alt_cout, alt_sum}, {15'd0, 1'b0, 16'h5555});
        check({name, "_rdy"}, alt_ready, 1);
        a = 16'hFFFF; b = 16'h0001; st_alt = 1;
        @(negedge clk); st_alt = 0;
        wait_alt(n);
        check({name, "_interval"}, n + 1, ndig + 1);
        check({name, "_r2"}, {alt_cout, alt_sum}, {15'd0, 1'b1, 16'h0000});
    endtask

    initial begin
        int n, cnt;
        repeat (2) @(negedge clk);
        rst_n = 1;
        chk_en = 1;
        check("reset_state", {ready, busy, done, cout, ovf, sum}, {11'd0, 5'b10000, 16'h0});

        // 1. basic add and latency
        go(16'h0001, 16'h0000, 0, 0); wait_done(n);
        check("t1_latency", n, 4);
        expect_res("t1a", 16'h0001, 0, 0);
        go(16'h000D, 16'h000A, 1, 0); wait_done(n);
        expect_res("t1b", 16'h0018, 0, 0);

        // 2. carry ripples through every digit
        go(16'hFFFF, 16'h0001, 0, 0); wait_done(n);
        expect_res("t2a", 16'h0000, 1, 0);
        go(16'hFFFF, 16'hFFFF, 1, 0); wait_done(n);
        expect_res("t2b", 16'hFFFF, 1, 0);

        // 3. signed overflow and subtraction (cin ignored for sub)
        go(16'h7FFF, 16'h0001, 0, 0); wait_done(n);
        expect_res("t3a", 16'h8000, 0, 1);
        go(16'h0005, 16'h0007, 0, 1); wait_done(n);
        expect_res("t3b", 16'hFFFE, 0, 0);
        go(16'h8000, 16'h0001, 1, 1); wait_done(n);
        expect_res("t3c", 16'h7FFF, 1, 1);

        // 4. inputs churn and start pulses while busy
        go(16'h1234, 16'h0FF0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom); sub = i[0]; cin = ~i[0];
            start = (i == 1);
            @(negedge clk);
        end
        start = 0;
        wait_done(n);
        expect_res("t4", 16'h2224, 0, 0);
        cnt = 0;
        repeat (8) begin @(negedge clk); if (done) cnt++; end
        check("t4_no_extra_done", cnt, 0);

        // 5. reset mid-operation
        go(16'h0F0F, 16'h0101, 0, 0);
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        check("t5_abort", {ready, busy, cout, ovf, sum}, {12'd0, 4'b1000, 16'h0});
        cnt = 0;
        repeat (8) begin @(negedge clk); if (done) cnt++; end
        check("t5_no_done", cnt, 0);
        go(16'h0F0F, 16'h0101, 0, 0); wait_done(n);
        expect_res("t5_after", 16'h1010, 0, 0);

        // 6. back-to-back issue from the DONE cycle
        go(16'h0100, 16'h0200, 0, 0); wait_done(n);
        expect_res("t6_first", 16'h0300, 0, 0);
        a = 16'h0003; b = 16'h0005; sub = 1; start = 1;
        @(negedge clk); start = 0;
        wait_done(n);
        check("t6_interval", n + 1, 5);
        expect_res("t6_second", 16'hFFFE, 0, 0);

        sel16 = 0; b2b_alt("d1", 16);
        sel16 = 1; b2b_alt("d16", 1);

        repeat (3) @(negedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
